// File: rtl/red_pitaya_na_sweep_sequencer_pkg.sv
// Shared constants, state encoding and address helper for the NA sweep sequencer.
package red_pitaya_na_pkg;

   // Default IQ block register map and sizing
   localparam logic [15:0] FREQ_ADDR_DEF = 16'h0108;
   localparam logic [15:0] SUM_ADDR_DEF  = 16'h0140;
   localparam int          IDXBITS_DEF   = 16;
   localparam int          TIMEOUT_DEF   = 1023;

   // Word offsets within the sum block (byte offset = 4 * word)
   localparam logic [1:0] WORD_I_LO = 2'd0;
   localparam logic [1:0] WORD_I_HI = 2'd1;
   localparam logic [1:0] WORD_Q_LO = 2'd2;
   localparam logic [1:0] WORD_Q_HI = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_FREQ,
      ST_POLL,
      ST_RD_SUM,
      ST_PUSH,
      ST_FIN
   } na_state_e;

   // Byte address of sum word k relative to the sum block base
   function automatic logic [15:0] sum_word_addr(input logic [15:0] base, input logic [1:0] k);
      return base + {12'd0, k, 2'b00};
   endfunction

endpackage

// File: rtl/red_pitaya_na_sweep_sequencer_if.sv
// Register bus between the sweep sequencer (master) and the IQ block port (slave).
interface red_pitaya_na_sweep_sequencer_if;
   logic [15:0] addr;
   logic        wen;
   logic        ren;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output addr, wen, ren, wdata, input  ack, rdata);
   modport slave  (input  addr, wen, ren, wdata, output ack, rdata);
endinterface

// File: rtl/red_pitaya_na_sweep_sequencer_bus_master.sv
// Single-transaction engine: one-cycle strobe, address/data held until ack,
// per-transaction ack timeout. A new request is only taken while idle.
module red_pitaya_na_bus_master
   import red_pitaya_na_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [15:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        timeout_o,
   output logic        pending_o,
   red_pitaya_na_sweep_sequencer_if.master bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          pending_q, pending_d;
   logic [15:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          launch;

   // Launch, ack and timeout decisions for the single outstanding transaction
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      pending_d = pending_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tmr_d     = tmr_q;
      launch    = req_i && !pending_q;
      done_o    = pending_q && bus.ack;
      timeout_o = pending_q && !bus.ack && (tmr_q == TW'(TIMEOUT - 1));
      if (launch) begin
         pending_d = 1'b1;
         addr_d    = addr_i;
         wdata_d   = wdata_i;
         tmr_d     = '0;
      end else if (done_o || timeout_o) begin
         pending_d = 1'b0;
      end else if (pending_q) begin
         tmr_d = tmr_q + TW'(1);
      end
   end

   // Transaction registers
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         pending_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         tmr_q     <= '0;
      end else begin
         pending_q <= pending_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tmr_q     <= tmr_d;
      end
   end

   // Strobe only in the launch cycle; address/data come from the request then, held after
   assign bus.wen   = launch && we_i;
   assign bus.ren   = launch && !we_i;
   assign bus.addr  = pending_q ? addr_q  : (launch ? addr_i  : '0);
   assign bus.wdata = pending_q ? wdata_q : (launch ? wdata_i : '0);

   assign rdata_o   = bus.rdata;
   assign pending_o = pending_q;

endmodule

// File: rtl/red_pitaya_na_sweep_sequencer.sv
// Autonomous network-analyzer sweep: per point, write the frequency, poll the
// averaging flag, read the I/Q sums and stream {index, I, Q} out via valid/ready.
module red_pitaya_na_sweep_sequencer
   import red_pitaya_na_pkg::*;
#(
   parameter logic [15:0] FREQ_ADDR = FREQ_ADDR_DEF,
   parameter logic [15:0] SUM_ADDR  = SUM_ADDR_DEF,
   parameter int          IDXBITS   = IDXBITS_DEF,
   parameter int          TIMEOUT   = TIMEOUT_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [31:0]        cfg_freq_i,
   input  logic [31:0]        cfg_step_i,
   input  logic [IDXBITS-1:0] cfg_points_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic               aborted_o,
   red_pitaya_na_sweep_sequencer_if.master m_bus,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [IDXBITS-1:0] res_idx_o,
   output logic [61:0]        res_i_o,
   output logic [61:0]        res_q_o
);

   na_state_e          state_q, state_d;
   logic [IDXBITS-1:0] idx_q, idx_d, points_q, points_d;
   logic [31:0]        freq_q, freq_d, step_q, step_d;
   logic [1:0]         word_q, word_d;
   logic [61:0]        i_sum_q, i_sum_d, q_sum_q, q_sum_d;
   logic               abort_q, abort_d, err_q, err_d, aborted_q, aborted_d;

   logic               bm_req, bm_we, bm_done, bm_timeout, bm_pending;
   logic [15:0]        bm_addr;
   logic [31:0]        bm_wdata, bm_rdata;
   logic               abort_pend, last_point, busy;

   red_pitaya_na_bus_master #(.TIMEOUT(TIMEOUT)) u_bus_master (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (bm_req),
      .we_i      (bm_we),
      .addr_i    (bm_addr),
      .wdata_i   (bm_wdata),
      .done_o    (bm_done),
      .rdata_o   (bm_rdata),
      .timeout_o (bm_timeout),
      .pending_o (bm_pending),
      .bus       (m_bus)
   );

   assign busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign abort_pend = abort_q || abort_i;
   assign last_point = (idx_q == points_q - IDXBITS'(1));

   // Sweep FSM next-state, counters, sum assembly and bus requests
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      points_d  = points_q;
      freq_d    = freq_q;
      step_d    = step_q;
      word_d    = word_q;
      i_sum_d   = i_sum_q;
      q_sum_d   = q_sum_q;
      err_d     = err_q;
      aborted_d = aborted_q;
      abort_d   = busy ? abort_pend : abort_q;
      bm_req    = 1'b0;
      bm_we     = 1'b0;
      bm_addr   = FREQ_ADDR;
      bm_wdata  = freq_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               points_d  = cfg_points_i;
               step_d    = cfg_step_i;
               freq_d    = cfg_freq_i;
               idx_d     = '0;
               err_d     = 1'b0;
               aborted_d = 1'b0;
               abort_d   = 1'b0;
               state_d   = (cfg_points_i == '0) ? ST_FIN : ST_WR_FREQ;
            end
         end
         ST_WR_FREQ: begin
            bm_we = 1'b1;
            if (!bm_pending) begin
               if (abort_pend) begin
                  aborted_d = 1'b1;
                  state_d   = ST_FIN;
               end else begin
                  bm_req = 1'b1;
               end
            end else if (bm_done) begin
               if (abort_pend) begin
                  aborted_d = 1'b1;
                  state_d   = ST_FIN;
               end else begin
                  state_d = ST_POLL;
               end
            end
         end
         ST_POLL: begin
            bm_addr = SUM_ADDR;
            bm_req  = !bm_pending;
            if (bm_done) begin
               if (abort_pend) begin
                  aborted_d = 1'b1;
                  state_d   = ST_FIN;
               end else if (!bm_rdata[31]) begin
                  word_d  = WORD_I_LO;
                  state_d = ST_RD_SUM;
               end
            end
         end
         ST_RD_SUM: begin
            bm_addr = sum_word_addr(SUM_ADDR, word_q);
            bm_req  = !bm_pending;
            if (bm_done) begin
               unique case (word_q)
                  WORD_I_LO: i_sum_d[30:0]  = bm_rdata[30:0];
                  WORD_I_HI: i_sum_d[61:31] = bm_rdata[30:0];
                  WORD_Q_LO: q_sum_d[30:0]  = bm_rdata[30:0];
                  default:   q_sum_d[61:31] = bm_rdata[30:0];
               endcase
               if (abort_pend) begin
                  aborted_d = 1'b1;
                  state_d   = ST_FIN;
               end else if (word_q == WORD_Q_HI) begin
                  state_d = ST_PUSH;
               end else begin
                  word_d = word_q + 2'd1;
               end
            end
         end
         ST_PUSH: begin
            if (abort_pend) begin
               aborted_d = 1'b1;
               state_d   = ST_FIN;
            end else if (res_ready_i) begin
               if (last_point) begin
                  state_d = ST_FIN;
               end else begin
                  idx_d   = idx_q + IDXBITS'(1);
                  freq_d  = freq_q + step_q;
                  state_d = ST_WR_FREQ;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (bm_timeout) begin
         err_d   = 1'b1;
         state_d = ST_FIN;
      end
   end

   // Sweep state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         points_q  <= '0;
         freq_q    <= '0;
         step_q    <= '0;
         word_q    <= '0;
         // NOTE: the sum regs are reset as well because they drive res_i_o/res_q_o directly.
         i_sum_q   <= '0;
         q_sum_q   <= '0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         points_q  <= points_d;
         freq_q    <= freq_d;
         step_q    <= step_d;
         word_q    <= word_d;
         i_sum_q   <= i_sum_d;
         q_sum_q   <= q_sum_d;
         abort_q   <= abort_d;
         err_q     <= err_d;
         aborted_q <= aborted_d;
      end
   end

   assign busy_o      = busy;
   assign done_o      = (state_q == ST_FIN);
   assign err_o       = err_q;
   assign aborted_o   = aborted_q;
   assign res_valid_o = (state_q == ST_PUSH);
   assign res_idx_o   = idx_q;
   assign res_i_o     = i_sum_q;
   assign res_q_o     = q_sum_q;

endmodule

// File: tb/tb_red_pitaya_na_sweep_sequencer.sv
// Self-checking bench: behavioural IQ block model on the bus, random sweeps,
// directed corner cases; expected results come from the sweep rules directly.
module tb_red_pitaya_na_sweep_sequencer;

   localparam logic [15:0] FREQ_A = 16'h0108;
   localparam logic [15:0] SUM_A  = 16'h0140;

   typedef struct {
      logic [15:0] idx;
      logic [61:0] i;
      logic [61:0] q;
   } res_t;

   logic        clk = 1'b0;
   logic        rst, start, abort, ready;
   logic [31:0] cfg_freq, cfg_step;
   logic [15:0] cfg_points;
   logic        busy, done, err, aborted, res_valid;
   logic [15:0] res_idx;
   logic [61:0] res_i, res_q;

   red_pitaya_na_sweep_sequencer_if bus ();

   red_pitaya_na_sweep_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .cfg_freq_i   (cfg_freq),
      .cfg_step_i   (cfg_step),
      .cfg_points_i (cfg_points),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .aborted_o    (aborted),
      .m_bus        (bus),
      .res_valid_o  (res_valid),
      .res_ready_i  (ready),
      .res_idx_o    (res_idx),
      .res_i_o      (res_i),
      .res_q_o      (res_q)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // IQ block model and monitor state
   bit          ack_en = 1'b1;
   bit          fixed_words = 1'b0;
   logic [31:0] fixed_w [4];
   logic [31:0] words [4];
   int          avg_cnt = 0;
   bit          ack_pend = 1'b0;
   logic [31:0] rdata_pend = '0;
   bit          outstanding = 1'b0;
   logic [31:0] wr_log [$];
   logic [61:0] exp_i [$];
   logic [61:0] exp_q [$];
   res_t        got [$];
   int          lat_q [$];
   int          strobes = 0, viol = 0, stall_viol = 0, done_cnt = 0, cyc = 0, acc_cyc = 0;
   bit          have_accept = 1'b0, stall_prev = 1'b0;
   res_t        held;

   // Sum value from a lo/hi word pair: 31 payload bits each, hi weighted by 2^31
   function automatic logic [61:0] assemble(input logic [31:0] lo, input logic [31:0] hi);
      logic [63:0] v;
      v = 64'(hi & 32'h7FFF_FFFF) * 64'h8000_0000 + 64'(lo & 32'h7FFF_FFFF);
      return v[61:0];
   endfunction

   function automatic logic [31:0] read_word(input logic [15:0] a);
      case (a)
         SUM_A:         return {(avg_cnt > 0), words[0][30:0]};
         SUM_A + 16'h4: return words[1];
         SUM_A + 16'h8: return words[2];
         SUM_A + 16'hC: return words[3];
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Bus slave (ack one cycle after strobe) plus result/protocol monitor, away from posedge
   always @(negedge clk) begin
      if (rst) begin
         bus.ack     = 1'b0;
         bus.rdata   = '0;
         ack_pend    = 1'b0;
         outstanding = 1'b0;
         avg_cnt     = 0;
         stall_prev  = 1'b0;
      end else begin
         cyc++;
         bus.ack   = ack_pend;
         bus.rdata = rdata_pend;
         ack_pend  = 1'b0;
         if (avg_cnt > 0) avg_cnt--;
         if (bus.wen || bus.ren) begin
            strobes++;
            if ((bus.wen && bus.ren) || outstanding) viol++;
         end
         if (bus.ack) outstanding = 1'b0;
         if (bus.wen && bus.addr == FREQ_A) begin
            wr_log.push_back(bus.wdata);
            avg_cnt = 20;
            for (int k = 0; k < 4; k++) words[k] = fixed_words ? fixed_w[k] : $urandom;
            exp_i.push_back(assemble(words[0], words[1]));
            exp_q.push_back(assemble(words[2], words[3]));
            if (have_accept) lat_q.push_back(cyc - acc_cyc);
            have_accept = 1'b0;
         end
         if (bus.ren) rdata_pend = read_word(bus.addr);
         if ((bus.wen || bus.ren) && ack_en) begin
            ack_pend    = 1'b1;
            outstanding = 1'b1;
         end
         if (res_valid && (bus.wen || bus.ren)) stall_viol++;
         if (stall_prev && (!res_valid || res_idx !== held.idx || res_i !== held.i || res_q !== held.q))
            stall_viol++;
         stall_prev = res_valid && !ready;
         held.idx = res_idx;
         held.i   = res_i;
         held.q   = res_q;
         if (res_valid && ready) begin
            got.push_back(held);
            acc_cyc     = cyc;
            have_accept = 1'b1;
         end
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      wr_log.delete();
      exp_i.delete();
      exp_q.delete();
      got.delete();
      lat_q.delete();
      have_accept = 1'b0;
      viol        = 0;
      stall_viol  = 0;
   endtask

   bit err_at_start, aborted_at_start;
   int done_before;

   // Start a sweep and run it to done_o; rmode 0 = always ready, 1 = random ready, 2 = one 50-cycle stall
   task automatic run_sweep(input logic [31:0] f, input logic [31:0] s, input logic [15:0] p,
                            input int rmode);
      bit stalled = 1'b0;
      int snap;
      clear_logs();
      done_before = done_cnt;
      cfg_freq = f; cfg_step = s; cfg_points = p;
      start = 1'b1;
      ready = 1'b1;
      tick();
      start = 1'b0;
      err_at_start     = err;
      aborted_at_start = aborted;
      for (int c = 0; c < 4000 && done_cnt == done_before; c++) begin
         ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rmode == 2 && !stalled && res_valid) begin
            stalled = 1'b1;
            ready   = 1'b0;
            snap    = strobes;
            repeat (50) tick();
            check("stall_no_strobe", strobes - snap, 0);
            ready = 1'b1;
         end
         tick();
      end
      check("sweep_done_seen", (done_cnt != done_before), 1);
      if (rmode == 2) check("stall_happened", stalled, 1);
      ready = 1'b1;
      repeat (3) tick();
   endtask

   // Compare one completed sweep against the rules: freq_n = f + n*s mod 2^32, results in index order
   task automatic verify_sweep(input string tag, input logic [31:0] f, input logic [31:0] s,
                               input logic [15:0] p);
      logic [31:0] ef;
      check({tag, "_n_writes"}, wr_log.size(), p);
      for (int n = 0; n < wr_log.size() && n < int'(p); n++) begin
         ef = f + s * 32'(n);
         check({tag, "_freq_wr"}, wr_log[n], ef);
      end
      check({tag, "_n_results"}, got.size(), p);
      for (int n = 0; n < got.size() && n < exp_i.size(); n++) begin
         check({tag, "_idx"}, got[n].idx, n);
         check({tag, "_res_i"}, got[n].i, exp_i[n]);
         check({tag, "_res_q"}, got[n].q, exp_q[n]);
      end
      check({tag, "_n_lat"}, lat_q.size(), p - 1);
      foreach (lat_q[n]) check({tag, "_next_latency"}, lat_q[n], 1);
      check({tag, "_bus_protocol"}, viol, 0);
      check({tag, "_push_stable"}, stall_viol, 0);
      check({tag, "_done_once"}, done_cnt - done_before, 1);
      check({tag, "_busy_low"}, busy, 0);
      check({tag, "_err_low"}, err, 0);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int snap, n, d0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
      cfg_freq = '0; cfg_step = '0; cfg_points = '0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_aborted", aborted, 0);
      check("rst_valid", res_valid, 0);
      check("rst_strobes", {bus.wen, bus.ren}, 0);
      check("rst_addr", bus.addr, 0);
      check("rst_res", {res_idx, res_i[15:0]}, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Basic three-point sweep
      run_sweep(32'd1000, 32'd100, 16'd3, 0);
      verify_sweep("basic", 32'd1000, 32'd100, 16'd3);

      // Zero points: done next cycle, no traffic
      clear_logs();
      snap = strobes; d0 = done_cnt;
      cfg_points = '0; start = 1'b1;
      tick();
      start = 1'b0;
      check("p0_done_next", done, 1);
      check("p0_busy", busy, 0);
      tick();
      check("p0_done_pulse", done, 0);
      repeat (3) tick();
      check("p0_strobes", strobes - snap, 0);
      check("p0_results", got.size(), 0);
      check("p0_done_count", done_cnt - d0, 1);

      // Frequency wrap modulo 2^32
      run_sweep(32'hFFFF_FFF0, 32'h20, 16'd2, 0);
      verify_sweep("wrap", 32'hFFFF_FFF0, 32'h20, 16'd2);
      if (wr_log.size() == 2) check("wrap_second_freq", wr_log[1], 32'h0000_0010);

      // Fixed sum words exercising the 31-bit split
      fixed_w[0] = 32'h7FFF_FFFF; fixed_w[1] = 32'h0000_0001;
      fixed_w[2] = 32'h0000_0000; fixed_w[3] = 32'h7FFF_FFFF;
      fixed_words = 1'b1;
      run_sweep(32'd5, 32'd1, 16'd1, 0);
      fixed_words = 1'b0;
      check("fixed_n", got.size(), 1);
      if (got.size() == 1) begin
         check("fixed_res_i", got[0].i, 62'h0000_0000_FFFF_FFFF);
         check("fixed_res_q", got[0].q, 62'h3FFF_FFFF_8000_0000);
      end

      // Back-pressure: 50-cycle stall in PUSH
      run_sweep(32'h1234_0000, 32'h10, 16'd2, 2);
      verify_sweep("stall", 32'h1234_0000, 32'h10, 16'd2);

      // Abort while polling
      clear_logs();
      d0 = done_cnt;
      cfg_freq = 32'd777; cfg_step = 32'd1; cfg_points = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      snap = strobes;
      for (int c = 0; c < 100 && done_cnt == d0; c++) tick();
      repeat (3) tick();
      check("abort_no_more_strobes", strobes - snap, 0);
      check("abort_flag", aborted, 1);
      check("abort_done_once", done_cnt - d0, 1);
      check("abort_busy_low", busy, 0);
      check("abort_no_results", got.size(), 0);
      check("abort_protocol", viol, 0);

      // Next sweep clears aborted_o
      run_sweep(32'd40, 32'd3, 16'd1, 0);
      check("aborted_cleared", aborted_at_start, 0);
      verify_sweep("post_abort", 32'd40, 32'd3, 16'd1);

      // start and abort together while idle: abort wins
      snap = strobes; d0 = done_cnt;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      repeat (5) tick();
      check("start_abort_busy", busy, 0);
      check("start_abort_strobes", strobes - snap, 0);
      check("start_abort_done", done_cnt - d0, 0);

      // Ack timeout
      clear_logs();
      ack_en = 1'b0;
      cfg_freq = 32'd9; cfg_step = 32'd1; cfg_points = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!err && n < 1200) begin
         tick();
         n++;
      end
      check("tmo_err", err, 1);
      check("tmo_window", (n >= 1020 && n <= 1030), 1);
      check("tmo_busy_low", busy, 0);
      check("tmo_done", done, 1);
      repeat (3) tick();
      ack_en = 1'b1;
      run_sweep(32'd100, 32'd7, 16'd1, 0);
      check("err_cleared", err_at_start, 0);
      verify_sweep("post_tmo", 32'd100, 32'd7, 16'd1);

      // Random sweeps with random back-pressure
      for (int r = 0; r < 6; r++) begin
         logic [31:0] rf, rs;
         logic [15:0] rp;
         rf = $urandom;
         rs = $urandom;
         rp = 16'($urandom_range(1, 4));
         run_sweep(rf, rs, rp, 1);
         verify_sweep("rand", rf, rs, rp);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
